// File: rtl/run_detector.sv
// rtl/run_detector.sv - run-length detector with optional event counter (RUN_DETECT_EVCNT_EN)
module run_detector #(
  parameter int RUN_LEN = 8,
  parameter int EVCNT_W = 16
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic               en,
  input  logic               din,
  input  logic               polarity,
  input  logic               mode,
  input  logic               ev_clr,
  output logic               pulse,
  output logic               active,
  output logic [7:0]         run_cnt
`ifdef RUN_DETECT_EVCNT_EN
  ,
  output logic [EVCNT_W-1:0] ev_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [8:0] RUN_LEN_9 = 9'(RUN_LEN);
  localparam logic [7:0] RUN_LEN_8 = 8'(RUN_LEN);

  state_t      state_q, state_d;
  logic [7:0]  run_q, run_d;
  logic        pulse_q, pulse_d;
  logic [8:0]  run_inc;
  logic        match;

  assign match   = (din == polarity);
  assign run_inc = {1'b0, run_q} + 9'd1;

  // Next-state, next run length and detection strobe for the accepted sample
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE, COUNT: begin
        if (en) begin
          if (!match) begin
            state_d = IDLE;
            run_d   = '0;
          end else if (run_inc < RUN_LEN_9) begin
            state_d = COUNT;
            run_d   = run_inc[7:0];
          end else begin
            // Terminal match: mode only matters here
            pulse_d = 1'b1;
            if (mode) begin
              state_d = COUNT;
              run_d   = '0;
            end else begin
              state_d = HOLD;
              run_d   = RUN_LEN_8;
            end
          end
        end
      end
      HOLD: begin
        if (en) begin
          if (!match) begin
            state_d = IDLE;
            run_d   = '0;
          end else begin
            state_d = HOLD;
            run_d   = RUN_LEN_8;
          end
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = '0;
      end
    endcase
  end

  // State, run length and strobe registers
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      run_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse   = pulse_q;
  assign run_cnt = run_q;
  assign active  = (state_q != IDLE);

`ifdef RUN_DETECT_EVCNT_EN
  logic [EVCNT_W-1:0] ev_q;

  // Saturating detection counter; clear wins over a simultaneous increment
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ev_q <= '0;
    end else if (ev_clr) begin
      ev_q <= '0;
    end else if (pulse_d && (ev_q != {EVCNT_W{1'b1}})) begin
      ev_q <= ev_q + EVCNT_W'(1);
    end
  end

  assign ev_cnt = ev_q;
`else
  logic ev_clr_unused;
  assign ev_clr_unused = ev_clr;
`endif

endmodule

// File: tb/tb_run_detector.sv
// tb/tb_run_detector.sv - self-checking bench for run_detector (RUN_LEN 8 and 1)
module tb_run_detector;

  logic       clk = 1'b0;
  logic       areset_n = 1'b1;
  logic       en = 1'b0, din = 1'b0, polarity = 1'b0, mode = 1'b0, ev_clr = 1'b0;
  logic       pulse0, active0, pulse1, active1;
  logic [7:0] run0, run1;
`ifdef RUN_DETECT_EVCNT_EN
  logic [1:0]  ev0;
  logic [15:0] ev1;
`endif

  int total = 0;
  int bad   = 0;

  run_detector #(.RUN_LEN(8), .EVCNT_W(2)) dut0 (
    .clk(clk), .areset_n(areset_n), .en(en), .din(din), .polarity(polarity),
    .mode(mode), .ev_clr(ev_clr), .pulse(pulse0), .active(active0), .run_cnt(run0)
`ifdef RUN_DETECT_EVCNT_EN
    , .ev_cnt(ev0)
`endif
  );

  run_detector #(.RUN_LEN(1), .EVCNT_W(16)) dut1 (
    .clk(clk), .areset_n(areset_n), .en(en), .din(din), .polarity(polarity),
    .mode(mode), .ev_clr(ev_clr), .pulse(pulse1), .active(active1), .run_cnt(run1)
`ifdef RUN_DETECT_EVCNT_EN
    , .ev_cnt(ev1)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: streak of consecutive accepted matches since the last
  // mismatch/reset, the streak value at the last retrigger, and a one-shot hold flag.
  int rl[2]    = '{8, 1};
  int evmax[2] = '{3, 65535};
  int streak[2], base[2], ev[2];
  bit held[2], mp[2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      streak[d] = 0; base[d] = 0; held[d] = 0; mp[d] = 0; ev[d] = 0;
    end
  endfunction

  function automatic void model_step(input logic e, d_in, p, m, c);
    for (int d = 0; d < 2; d++) begin
      mp[d] = 0;
      if (e) begin
        if (d_in != p) begin
          streak[d] = 0; base[d] = 0; held[d] = 0;
        end else begin
          streak[d]++;
          if (!held[d] && (streak[d] - base[d] == rl[d])) begin
            mp[d] = 1;
            if (m) base[d] = streak[d];
            else   held[d] = 1;
          end
        end
      end
      if (c) ev[d] = 0;
      else if (mp[d] && ev[d] < evmax[d]) ev[d]++;
    end
  endfunction

  task automatic check_model();
    chk("m_pulse0",  int'(pulse0),  int'(mp[0]));
    chk("m_run0",    int'(run0),    held[0] ? rl[0] : streak[0] - base[0]);
    chk("m_active0", int'(active0), int'(streak[0] > 0));
    chk("m_pulse1",  int'(pulse1),  int'(mp[1]));
    chk("m_run1",    int'(run1),    held[1] ? rl[1] : streak[1] - base[1]);
    chk("m_active1", int'(active1), int'(streak[1] > 0));
`ifdef RUN_DETECT_EVCNT_EN
    chk("m_ev0", int'(ev0), ev[0]);
    chk("m_ev1", int'(ev1), ev[1]);
`endif
  endtask

  task automatic cyc(input logic e, d_in, p, m, c);
    @(negedge clk);
    en = e; din = d_in; polarity = p; mode = m; ev_clr = c;
    model_step(e, d_in, p, m, c);
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Asynchronous reset between edges, checked before any clock edge
  task automatic mid_reset();
    @(negedge clk);
    #2 areset_n = 1'b0;
    en = 1'b0;
    #1;
    chk("rst_pulse0",  int'(pulse0),  0);
    chk("rst_run0",    int'(run0),    0);
    chk("rst_active0", int'(active0), 0);
    chk("rst_pulse1",  int'(pulse1),  0);
`ifdef RUN_DETECT_EVCNT_EN
    chk("rst_ev0", int'(ev0), 0);
`endif
    model_reset();
    @(negedge clk);
    #2 areset_n = 1'b1;
  endtask

  typedef struct {
    logic e, d, p, m;
    logic exp_pulse;
    int   exp_run;
    logic exp_active;
  } vec_t;

  function automatic vec_t mk(logic e, d, p, m, logic xp, int xr, logic xa);
    vec_t v;
    v.e = e; v.d = d; v.p = p; v.m = m;
    v.exp_pulse = xp; v.exp_run = xr; v.exp_active = xa;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   np, pidx;
    logic p, m;

    // Power-on reset
    #2 areset_n = 1'b0;
    #1;
    chk("por_pulse0",  int'(pulse0),  0);
    chk("por_run0",    int'(run0),    0);
    chk("por_active0", int'(active0), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2 areset_n = 1'b1;

    // Zeros 1..7, a one, then eight zeros (one-shot), then one more zero held
    for (int i = 1; i <= 7; i++) tbl.push_back(mk(1, 0, 0, 0, 0, i, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 7; i++) tbl.push_back(mk(1, 0, 0, 0, 0, i, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 8, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      cyc(tbl[i].e, tbl[i].d, tbl[i].p, tbl[i].m, 1'b0);
      chk($sformatf("tbl%0d_pulse", i),  int'(pulse0),  int'(tbl[i].exp_pulse));
      chk($sformatf("tbl%0d_run", i),    int'(run0),    tbl[i].exp_run);
      chk($sformatf("tbl%0d_active", i), int'(active0), int'(tbl[i].exp_active));
    end

    // One-shot: 12 zeros give exactly one pulse after the 8th
    cyc(1, 1, 0, 0, 0);
    np = 0; pidx = -1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (pulse0) begin np++; pidx = i; end
    end
    chk("oneshot_npulse", np, 1);
    chk("oneshot_pidx", pidx, 8);
    chk("oneshot_run", int'(run0), 8);
    chk("oneshot_active", int'(active0), 1);

    // Retrigger: 16 zeros give pulses after the 8th and 16th
    cyc(1, 1, 0, 1, 0);
    np = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 0, 1, 0);
      if (pulse0) begin
        np++;
        chk("retrig_pidx", i % 8, 0);
        chk("retrig_run", int'(run0), 0);
      end
    end
    chk("retrig_npulse", np, 2);

    // Seven matches, en low for 5 cycles, then the 8th accepted match
    cyc(1, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("gap_run", int'(run0), 7);
      chk("gap_pulse", int'(pulse0), 0);
    end
    cyc(1, 0, 0, 0, 0);
    chk("gap_final_pulse", int'(pulse0), 1);

    // Reset at run_cnt=5, then a fresh 8-match run is needed
    cyc(1, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(1, 0, 0, 0, 0);
    chk("pre_rst_run", int'(run0), 5);
    mid_reset();
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("post_rst_nopulse", int'(pulse0), 0);
    end
    cyc(1, 0, 0, 0, 0);
    chk("post_rst_pulse", int'(pulse0), 1);

`ifdef RUN_DETECT_EVCNT_EN
    // Saturating 2-bit counter over five retrigger detections, then clear vs pulse
    cyc(1, 1, 0, 1, 1);
    chk("ev_clr0", int'(ev0), 0);
    for (int k = 1; k <= 5; k++) begin
      for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 1, 0);
      chk("ev_sat_pulse", int'(pulse0), 1);
      chk("ev_sat", int'(ev0), (k < 3) ? k : 3);
    end
    for (int i = 1; i <= 7; i++) cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 1);
    chk("ev_clr_pulse", int'(pulse0), 1);
    chk("ev_clr_prio", int'(ev0), 0);
`endif

    // Randomized run against the model
    p = 1'b0; m = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) mid_reset();
      if ($urandom_range(0, 59) == 0) p = ~p;
      if ($urandom_range(0, 19) == 0) m = ~m;
      cyc(($urandom_range(0, 3) != 0),
          ($urandom_range(0, 11) != 0) ? p : ~p,
          p, m, ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
